// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner: FSM states, the key
// legend lookup and the one-hot-low drive encoder.
package keypad_pkg;

   typedef enum logic [1:0] {
      StScan,
      StDebounce,
      StHold
   } state_e;

   // Indexed by {row, col}; legend of the Pmod KYPD.
   localparam logic [3:0] KEY_MAP [16] = '{
      4'h1, 4'h2, 4'h3, 4'hA,
      4'h4, 4'h5, 4'h6, 4'hB,
      4'h7, 4'h8, 4'h9, 4'hC,
      4'h0, 4'hF, 4'hE, 4'hD
   };

   function automatic logic [3:0] onehot_low(input logic [1:0] idx);
      logic [3:0] pat;
      pat = 4'b1111;
      pat[idx] = 1'b0;
      return pat;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs; resets to all-ones so
// idle pulled-up lines read as released.
module sync_2ff #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             clr,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta_q;
   logic [WIDTH-1:0] sync_q;

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         meta_q <= '1;
         sync_q <= '1;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: rotates an active-low column drive, debounces a
// single pressed key and shifts accepted hex codes into a 4-digit register.
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int unsigned COL_DWELL    = 100000,
   parameter int unsigned DEBOUNCE_CYC = 2000000
) (
   input  logic        clk,
   input  logic        clr,
   input  logic [3:0]  row,
   output logic [3:0]  col,
   output logic [3:0]  key_code,
   output logic        key_valid,
   output logic [15:0] digits
);

   localparam int unsigned CntMax = (COL_DWELL > DEBOUNCE_CYC) ? COL_DWELL : DEBOUNCE_CYC;
   localparam int unsigned CntW   = $clog2(CntMax);

   localparam logic [CntW-1:0] DwellLast = CntW'(COL_DWELL - 1);
   localparam logic [CntW-1:0] DebLast   = CntW'(DEBOUNCE_CYC - 1);
   localparam logic [CntW-1:0] CntOne    = CntW'(1);

   logic [3:0]      rs;
   state_e          state_q, state_d;
   logic [1:0]      col_idx_q, col_idx_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [1:0]      cand_row_q, cand_row_d;
   logic [3:0]      col_q;
   logic [3:0]      key_code_q, key_code_d;
   logic            key_valid_q, key_valid_d;
   logic [15:0]     digits_q, digits_d;
   logic            single_low;
   logic [1:0]      low_idx;
   logic [3:0]      new_code;

   sync_2ff #(
      .WIDTH(4)
   ) u_row_sync (
      .clk(clk),
      .clr(clr),
      .d  (row),
      .q  (rs)
   );

   // Exactly one row low; anything else is idle or a ghosting multi-press.
   always_comb begin
      single_low = 1'b1;
      low_idx    = 2'd0;
      unique case (rs)
         4'b1110: low_idx = 2'd0;
         4'b1101: low_idx = 2'd1;
         4'b1011: low_idx = 2'd2;
         4'b0111: low_idx = 2'd3;
         default: single_low = 1'b0;
      endcase
   end

   assign new_code = KEY_MAP[{cand_row_q, col_idx_q}];

   always_comb begin
      state_d     = state_q;
      col_idx_d   = col_idx_q;
      cnt_d       = cnt_q;
      cand_row_d  = cand_row_q;
      key_code_d  = key_code_q;
      key_valid_d = 1'b0;
      digits_d    = digits_q;

      unique case (state_q)
         StScan: begin
            if (cnt_q == DwellLast) begin
               cnt_d = '0;
               if (single_low) begin
                  cand_row_d = low_idx;
                  state_d    = StDebounce;
               end else begin
                  col_idx_d = col_idx_q + 2'd1;
               end
            end else begin
               cnt_d = cnt_q + CntOne;
            end
         end

         StDebounce: begin
            if (rs == onehot_low(cand_row_q)) begin
               if (cnt_q == DebLast) begin
                  key_valid_d = 1'b1;
                  key_code_d  = new_code;
                  digits_d    = {digits_q[11:0], new_code};
                  cnt_d       = '0;
                  state_d     = StHold;
               end else begin
                  cnt_d = cnt_q + CntOne;
               end
            end else begin
               cnt_d     = '0;
               col_idx_d = col_idx_q + 2'd1;
               state_d   = StScan;
            end
         end

         StHold: begin
            // Wait for a debounced release so a held key never repeats.
            if (rs == 4'b1111) begin
               if (cnt_q == DebLast) begin
                  cnt_d     = '0;
                  col_idx_d = col_idx_q + 2'd1;
                  state_d   = StScan;
               end else begin
                  cnt_d = cnt_q + CntOne;
               end
            end else begin
               cnt_d = '0;
            end
         end

         default: begin
            cnt_d   = '0;
            state_d = StScan;
         end
      endcase
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q     <= StScan;
         col_idx_q   <= 2'd0;
         cnt_q       <= '0;
         cand_row_q  <= 2'd0;
         col_q       <= 4'b1110;
         key_code_q  <= 4'h0;
         key_valid_q <= 1'b0;
         digits_q    <= 16'h0000;
      end else begin
         state_q     <= state_d;
         col_idx_q   <= col_idx_d;
         cnt_q       <= cnt_d;
         cand_row_q  <= cand_row_d;
         col_q       <= onehot_low(col_idx_d);
         key_code_q  <= key_code_d;
         key_valid_q <= key_valid_d;
         digits_q    <= digits_d;
      end
   end

   assign col       = col_q;
   assign key_code  = key_code_q;
   assign key_valid = key_valid_q;
   assign digits    = digits_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a modelled physical keypad plus directed and random
// press/bounce/ghost scenarios checked against a transaction-level model.
module tb_keypad_scanner;

   localparam int unsigned ColDwell = 8;
   localparam int unsigned DebCyc   = 16;
   localparam int          LatMax   = 4 * ColDwell + DebCyc + 3;

   logic        clk;
   logic        clr;
   logic [3:0]  row;
   logic [3:0]  col;
   logic [3:0]  key_code;
   logic        key_valid;
   logic [15:0] digits;

   logic [15:0] pressed;
   int unsigned pulses;
   int unsigned col_bad;
   int unsigned n_checks;
   int unsigned n_pass;
   logic [15:0] model_digits;
   logic [3:0]  model_code;

   keypad_scanner #(
      .COL_DWELL   (ColDwell),
      .DEBOUNCE_CYC(DebCyc)
   ) dut (
      .clk      (clk),
      .clr      (clr),
      .row      (row),
      .col      (col),
      .key_code (key_code),
      .key_valid(key_valid),
      .digits   (digits)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Physical switch matrix: a pressed key pulls its row low while its column is driven.
   always_comb begin
      row = 4'b1111;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (pressed[r*4+c] && !col[c]) row[r] = 1'b0;
   end

   always @(negedge clk) begin
      if (key_valid === 1'b1) pulses++;
      if (!(col inside {4'b1110, 4'b1101, 4'b1011, 4'b0111})) col_bad++;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic logic [3:0] key_of(input int r, input int c);
      string lbl = "123A456B789C0FED";
      logic [7:0] ch;
      ch = lbl[r*4+c];
      // ASCII hex digit to value.
      if (ch >= 8'h41) return 4'(ch - 8'h37);
      return 4'(ch - 8'h30);
   endfunction

   function automatic logic [3:0] col_of(input int idx);
      return 4'b1111 & ~(4'b0001 << idx);
   endfunction

   task automatic wait_valid(output bit ok, output int lat);
      lat = 0;
      while (key_valid !== 1'b1 && lat < LatMax) begin
         tick(1);
         lat++;
      end
      ok = (key_valid === 1'b1);
   endtask

   task automatic wait_col(input logic [3:0] pat, input int limit, output bit ok);
      int n = 0;
      while (col !== pat && n < limit) begin
         tick(1);
         n++;
      end
      ok = (col === pat);
   endtask

   task automatic press_key(input int r, input int c, input int hold, input int rel);
      int unsigned p0;
      int lat;
      bit ok;
      logic [3:0] k;
      k = key_of(r, c);
      p0 = pulses;
      pressed[r*4+c] = 1'b1;
      wait_valid(ok, lat);
      check("press_latency", 32'(ok), 1);
      if (hold > lat) tick(hold - lat);
      pressed[r*4+c] = 1'b0;
      tick(rel);
      model_code   = k;
      model_digits = {model_digits[11:0], k};
      check("press_pulses", pulses - p0, 1);
      check("press_code", key_code, model_code);
      check("press_digits", digits, model_digits);
   endtask

   task automatic glitch(input int r, input int c, input int len, input int rel);
      int unsigned p0;
      p0 = pulses;
      pressed[r*4+c] = 1'b1;
      tick(len);
      pressed[r*4+c] = 1'b0;
      tick(rel);
      check("glitch_pulses", pulses - p0, 0);
      check("glitch_digits", digits, model_digits);
   endtask

   task automatic ghost(input int r1, input int r2, input int c, input int hold, input int rel);
      int unsigned p0;
      p0 = pulses;
      pressed[r1*4+c] = 1'b1;
      pressed[r2*4+c] = 1'b1;
      tick(hold);
      pressed = '0;
      tick(rel);
      check("ghost_pulses", pulses - p0, 0);
      check("ghost_code", key_code, model_code);
   endtask

   initial begin
      int unsigned p0;
      int lat;
      bit ok;

      pressed = '0;
      pulses = 0;
      col_bad = 0;
      n_checks = 0;
      n_pass = 0;
      model_digits = '0;
      model_code = '0;
      clr = 1'b1;
      tick(3);
      check("reset_col", col, 4'b1110);
      check("reset_code", key_code, 4'h0);
      check("reset_valid", key_valid, 1'b0);
      check("reset_digits", digits, 16'h0000);
      clr = 1'b0;

      // Idle rotation: a new column every dwell period.
      for (int n = 1; n <= 40; n++) begin
         tick(1);
         if (n % 4 == 0) check("idle_col", col, col_of((n / ColDwell) % 4));
      end
      check("idle_pulses", pulses, 0);
      check("idle_digits", digits, 16'h0000);

      // Key 5 held 200 cycles; column stays put until the release is debounced.
      press_key(1, 1, 200, 0);
      check("hold_col_at_release", col, 4'b1101);
      tick(10);
      check("hold_col_release_10", col, 4'b1101);
      tick(12);
      check("hold_col_release_22", col, 4'b1011);
      check("key5_digits", digits, 16'h0005);
      tick(30);

      press_key(0, 0, 100, 100);
      press_key(0, 1, 100, 100);
      press_key(0, 2, 100, 100);
      press_key(0, 3, 100, 100);
      check("seq_digits", digits, 16'h123A);
      check("seq_code", key_code, 4'hA);

      // Bounce on D late in its column dwell.
      p0 = pulses;
      wait_col(4'b0111, 40, ok);
      check("bounce_find_col", 32'(ok), 1);
      tick(3);
      pressed[15] = 1'b1;
      tick(5);
      pressed[15] = 1'b0;
      tick(3);
      pressed[15] = 1'b1;
      tick(5);
      pressed[15] = 1'b0;
      wait_col(4'b1110, 40, ok);
      check("bounce_resume_col", 32'(ok), 1);
      tick(40);
      check("bounce_pulses", pulses - p0, 0);

      // Ghost: two rows low in column 0 must not stall the scan.
      p0 = pulses;
      wait_col(4'b1110, 40, ok);
      check("ghost_find_col", 32'(ok), 1);
      pressed[0] = 1'b1;
      pressed[8] = 1'b1;
      tick(9);
      check("ghost_col_advance", col, 4'b1101);
      tick(31);
      pressed = '0;
      tick(40);
      check("ghost_pulses_dir", pulses - p0, 0);

      // clr during HOLD after key 9; the still-held key is accepted again.
      pressed[10] = 1'b1;
      wait_valid(ok, lat);
      check("clr_first_accept", 32'(ok), 1);
      tick(5);
      #2 clr = 1'b1;
      #1;
      check("clr_col", col, 4'b1110);
      check("clr_digits", digits, 16'h0000);
      check("clr_code", key_code, 4'h0);
      model_digits = '0;
      model_code = '0;
      tick(2);
      clr = 1'b0;
      p0 = pulses;
      wait_valid(ok, lat);
      check("clr_reaccept", 32'(ok), 1);
      tick(20);
      pressed = '0;
      tick(40);
      model_code = 4'h9;
      model_digits = 16'h0009;
      check("clr_pulses", pulses - p0, 1);
      check("clr_rekey_digits", digits, 16'h0009);
      check("clr_rekey_code", key_code, 4'h9);

      for (int i = 0; i < 24; i++) begin
         int kind, r, c, r2;
         kind = $urandom_range(0, 9);
         r = $urandom_range(0, 3);
         c = $urandom_range(0, 3);
         if (kind <= 6) begin
            press_key(r, c, $urandom_range(60, 150), $urandom_range(40, 100));
         end else if (kind <= 8) begin
            glitch(r, c, $urandom_range(1, 10), $urandom_range(40, 100));
         end else begin
            r2 = (r + 1 + $urandom_range(0, 2)) % 4;
            ghost(r, r2, c, $urandom_range(60, 150), $urandom_range(40, 100));
         end
      end

      check("col_onehot_low", col_bad, 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
